// File: rtl/arb_pkg.sv
// +-----------------------------------------------------------------------+
// | arb_pkg : shared types and helpers for the round-robin grant arbiter  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// +-----------------------------------------------------------------------+
// | rr_pick4 : combinational rotating-priority picker, 4 requesters       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Scan ptr, ptr+1, ...; the 2-bit sum wraps naturally modulo 4.
  always_comb begin
    pick_oh = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = ptr + IDX_W'(k);
      if (!found && req[pos]) begin
        pick_oh[pos] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign pick_idx = oh_to_idx(pick_oh);
  assign pick_any = |req;

endmodule

`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
// +-----------------------------------------------------------------------+
// | rr_grant_arbiter : 4-way round-robin arbiter with hold-time limit     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick4 u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      grant     <= '0;
      grant_idx <= '0;
      grant_vld <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant     <= pick_oh;
            grant_idx <= pick_idx;
            grant_vld <= 1'b1;
            cnt       <= '0;
            state     <= ST_OWN;
          end
        end
        ST_OWN: begin
          // Voluntary release outranks the hold limit, so timeout only flags forced releases.
          if (!req[grant_idx] || cnt == HOLD_LAST) begin
            timeout   <= req[grant_idx];
            grant     <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
            ptr       <= grant_idx + IDX_W'(1);
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_rr_grant_arbiter : directed + random bench with reference model    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_rr_grant_arbiter;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_vld;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner number (-1 = none), cycles held so far, rotation start.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;
  bit prev_to = 1'b0;

  rr_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_update(input logic [3:0] r, input logic rs);
    if (rs) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_cnt   = 0;
          end
        end
      end else if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1;
      end else if (m_cnt == MAX_HOLD - 1) begin
        m_to = 1'b1; m_ptr = (m_owner + 1) % 4; m_owner = -1;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  // Advance one clock, then compare every output against the model and the invariants.
  task automatic step();
    logic [3:0] exp_g;
    @(posedge clk);
    model_update(req, rst);
    #1;
    exp_g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    chk("grant", 32'(grant), 32'(exp_g));
    chk("grant_idx", 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("grant_vld", 32'(grant_vld), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    chk("to_twice", 32'(prev_to & timeout), 32'd0);
    prev_to = timeout;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] seq [$];
    logic [3:0] last_g;
    int         held;

    // Reset state and first grant latency
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_vld", 32'(grant_vld), 32'h0);
    req = 4'b0001;
    step();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_idx", 32'(grant_idx), 32'h0);
    chk("t1_vld", 32'(grant_vld), 32'h1);

    // All requesting, each owner drops two cycles into its grant
    do_reset();
    last_g = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      req = 4'b1111;
      if (m_owner >= 0 && m_cnt == 1) req[m_owner] = 1'b0;
      step();
      if (grant !== last_g) seq.push_back(grant);
      last_g = grant;
    end
    chk("t2_len", (seq.size() >= 9) ? 32'd1 : 32'd0, 32'd1);
    if (seq.size() >= 9) begin
      chk("t2_g0", 32'(seq[0]), 32'h1);
      chk("t2_z0", 32'(seq[1]), 32'h0);
      chk("t2_g1", 32'(seq[2]), 32'h2);
      chk("t2_z1", 32'(seq[3]), 32'h0);
      chk("t2_g2", 32'(seq[4]), 32'h4);
      chk("t2_z2", 32'(seq[5]), 32'h0);
      chk("t2_g3", 32'(seq[6]), 32'h8);
      chk("t2_z3", 32'(seq[7]), 32'h0);
      chk("t2_g4", 32'(seq[8]), 32'h1);
    end

    // Hold limit: single requester held continuously
    do_reset();
    req = 4'b0100;
    step();
    held = 0;
    for (int c = 0; c < 40; c++) begin
      if (grant !== 4'b0100) break;
      held++;
      step();
    end
    chk("t3_held", 32'(held), 32'(MAX_HOLD));
    chk("t3_to", 32'(timeout), 32'h1);
    chk("t3_gap", 32'(grant), 32'h0);
    step();
    chk("t3_regrant", 32'(grant), 32'h4);
    chk("t3_to_low", 32'(timeout), 32'h0);

    // Pointer moves past a releasing owner
    do_reset();
    req = 4'b0100; step();
    req = 4'b0000; step();
    req = 4'b1001; step();
    chk("t4_first", 32'(grant), 32'h8);
    chk("t4_idx", 32'(grant_idx), 32'h3);
    req = 4'b0001; step(); step();
    chk("t4_second", 32'(grant), 32'h1);

    // Reset mid-grant
    do_reset();
    req = 4'b0100; step();
    chk("t5_owned", 32'(grant), 32'h4);
    rst = 1'b1; step();
    chk("t5_cleared", 32'(grant), 32'h0);
    chk("t5_vld", 32'(grant_vld), 32'h0);
    rst = 1'b0; req = 4'b0110; step();
    chk("t5_after", 32'(grant), 32'h2);

    // Non-owner requests toggled under a held grant
    do_reset();
    req = 4'b0001; step();
    for (int c = 0; c < 10; c++) begin
      req = {3'($urandom_range(0, 7)), 1'b1};
      step();
      chk("t6_grant", 32'(grant), 32'h1);
      chk("t6_idx", 32'(grant_idx), 32'h0);
    end

    // Random traffic with occasional reset
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
      if ($urandom_range(0, 9) == 0) req = 4'b0000;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
